// File: rtl/bomberman_pkg.sv
// Shared types and constants for the arena sprite sources.
package bomberman_pkg;
  localparam logic [7:0] TRANSPARENT = 8'd137;

  typedef enum logic [1:0] {IDLE, FUSE, BLAST} bomb_state_t;

  typedef logic [3:0] cell_t;
endpackage

// File: rtl/pix2cell.sv
// Combinational scan-position to grid-cell mapping, shared by the grid sprite sources.
module pix2cell
  import bomberman_pkg::*;
#(
  parameter int CELL_LOG2 = 5,
  parameter int ORIGIN_X  = 80,
  parameter int ORIGIN_Y  = 48,
  parameter int GRID_W    = 15,
  parameter int GRID_H    = 13
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  output cell_t       cx,
  output cell_t       cy,
  output logic        on_grid
);
  localparam logic [10:0] OX = 11'(ORIGIN_X);
  localparam logic [10:0] OY = 11'(ORIGIN_Y);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] sx;
  logic [10:0] sy;

  // Wrapped differences are harmless: the explicit origin compare rejects them.
  assign dx = x - OX;
  assign dy = y - OY;
  assign sx = dx >> CELL_LOG2;
  assign sy = dy >> CELL_LOG2;
  assign cx = sx[3:0];
  assign cy = sy[3:0];

  assign on_grid = (x >= OX) && (y >= OY) &&
                   (sx < 11'(GRID_W)) && (sy < 11'(GRID_H));
endmodule

// File: rtl/bomb_flame.sv
// Bomb and cross-flame sprite source. Optional flame shading: BOMB_FLAME_ANIM_EN.
module bomb_flame
  import bomberman_pkg::*;
#(
  parameter int          CELL_LOG2    = 5,
  parameter int          ORIGIN_X     = 80,
  parameter int          ORIGIN_Y     = 48,
  parameter int          GRID_W       = 15,
  parameter int          GRID_H       = 13,
  parameter int          RANGE        = 2,
  parameter int          FUSE_FRAMES  = 120,
  parameter int          BLAST_FRAMES = 30,
  parameter logic [7:0]  BOMB_IDX     = 8'd40,
  parameter logic [7:0]  FLAME_IDX    = 8'd60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        active,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        place_req,
  input  logic [3:0]  place_cx,
  input  logic [3:0]  place_cy,
  output logic [7:0]  bomb_color,
  output logic [7:0]  flame_color,
  output logic        busy,
  output logic        explode
);
  localparam int CW = 8;

  bomb_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  cell_t         bx_reg, bx_next;
  cell_t         by_reg, by_next;
  logic          explode_reg, explode_next;
  logic [7:0]    bomb_color_reg, flame_color_reg;
  logic [7:0]    flame_shade;

  cell_t pcx, pcy;
  logic  on_grid;
  cell_t ddx, ddy;
  logic  bomb_hit, flame_hit;

  pix2cell #(
    .CELL_LOG2 (CELL_LOG2),
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y),
    .GRID_W    (GRID_W),
    .GRID_H    (GRID_H)
  ) u_pix2cell (
    .x       (x),
    .y       (y),
    .cx      (pcx),
    .cy      (pcy),
    .on_grid (on_grid)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bx_next      = bx_reg;
    by_next      = by_reg;
    explode_next = 1'b0;
    case (state_reg)
      IDLE: begin
        // A same-cycle frame_tick is deliberately not counted here.
        if (place_req && (place_cx < 4'(GRID_W)) && (place_cy < 4'(GRID_H))) begin
          bx_next    = place_cx;
          by_next    = place_cy;
          cnt_next   = '0;
          state_next = FUSE;
        end
      end
      FUSE: begin
        if (frame_tick) begin
          if (cnt_reg == CW'(FUSE_FRAMES - 1)) begin
            cnt_next     = '0;
            state_next   = BLAST;
            explode_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      BLAST: begin
        if (frame_tick) begin
          if (cnt_reg == CW'(BLAST_FRAMES - 1)) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bx_reg      <= '0;
      by_reg      <= '0;
      explode_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bx_reg      <= bx_next;
      by_reg      <= by_next;
      explode_reg <= explode_next;
    end
  end

`ifdef BOMB_FLAME_ANIM_EN
  logic [1:0] anim_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anim_reg <= 2'd0;
    end else if (state_reg == FUSE && state_next == BLAST) begin
      anim_reg <= 2'd0;
    end else if (state_reg == BLAST && frame_tick) begin
      anim_reg <= anim_reg + 2'd1;
    end
  end

  assign flame_shade = FLAME_IDX + {6'd0, anim_reg};
`else
  assign flame_shade = FLAME_IDX;
`endif

  assign ddx = (pcx >= bx_reg) ? (pcx - bx_reg) : (bx_reg - pcx);
  assign ddy = (pcy >= by_reg) ? (pcy - by_reg) : (by_reg - pcy);

  assign bomb_hit  = (state_reg == FUSE) && on_grid && (pcx == bx_reg) && (pcy == by_reg);
  assign flame_hit = (state_reg == BLAST) && on_grid &&
                     (((pcy == by_reg) && (ddx <= 4'(RANGE))) ||
                      ((pcx == bx_reg) && (ddy <= 4'(RANGE))));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bomb_color_reg  <= TRANSPARENT;
      flame_color_reg <= TRANSPARENT;
    end else begin
      bomb_color_reg  <= (active && bomb_hit)  ? BOMB_IDX    : TRANSPARENT;
      flame_color_reg <= (active && flame_hit) ? flame_shade : TRANSPARENT;
    end
  end

  assign bomb_color  = bomb_color_reg;
  assign flame_color = flame_color_reg;
  assign busy        = (state_reg != IDLE);
  assign explode     = explode_reg;
endmodule

// File: tb/tb_bomb_flame.sv
// Scoreboard bench for bomb_flame: randomized scan/tick stimulus against a frame-level model.
module tb_bomb_flame;
  logic        clk;
  logic        reset_n;
  logic        frame_tick;
  logic        active;
  logic [10:0] x;
  logic [10:0] y;
  logic        place_req;
  logic [3:0]  place_cx;
  logic [3:0]  place_cy;
  logic [7:0]  bomb_color;
  logic [7:0]  flame_color;
  logic        busy;
  logic        explode;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] bomb;
    logic [7:0] flame;
    logic       busy;
    logic       explode;
  } exp_t;

  exp_t q[$];

  // Model: phase 0=idle 1=fuse 2=blast, frames counted within the phase.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_bx    = 0;
  int m_by    = 0;
  int m_anim  = 0;

  bomb_flame dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .active      (active),
    .x           (x),
    .y           (y),
    .place_req   (place_req),
    .place_cx    (place_cx),
    .place_cy    (place_cy),
    .bomb_color  (bomb_color),
    .flame_color (flame_color),
    .busy        (busy),
    .explode     (explode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bomb_color",  int'(bomb_color),  int'(e.bomb));
        chk("flame_color", int'(flame_color), int'(e.flame));
        chk("busy",        int'(busy),        int'(e.busy));
        chk("explode",     int'(explode),     int'(e.explode));
      end
    end
  end

  task automatic step(input bit pr, input int pcx, input int pcy, input bit tk,
                      input bit act, input int px, input int py);
    exp_t e;
    int  cx, cy, ddx, ddy, shade;
    bit  on, expl;
    @(negedge clk);
    place_req  = pr;
    place_cx   = pcx[3:0];
    place_cy   = pcy[3:0];
    frame_tick = tk;
    active     = act;
    x          = px[10:0];
    y          = py[10:0];

    on = (px >= 80) && (py >= 48) && ((px - 80) / 32 < 15) && ((py - 48) / 32 < 13);
    cx = (px - 80) / 32;
    cy = (py - 48) / 32;
    ddx = (cx > m_bx) ? cx - m_bx : m_bx - cx;
    ddy = (cy > m_by) ? cy - m_by : m_by - cy;
`ifdef BOMB_FLAME_ANIM_EN
    shade = 60 + m_anim;
`else
    shade = 60;
`endif
    e.bomb  = (act && on && m_phase == 1 && cx == m_bx && cy == m_by) ? 8'd40 : 8'd137;
    e.flame = (act && on && m_phase == 2 &&
               ((cy == m_by && ddx <= 2) || (cx == m_bx && ddy <= 2))) ? shade[7:0] : 8'd137;

    expl = 1'b0;
    case (m_phase)
      0: if (pr && pcx < 15 && pcy < 13) begin
           m_phase = 1; m_cnt = 0; m_bx = pcx; m_by = pcy;
         end
      1: if (tk) begin
           m_cnt++;
           if (m_cnt == 120) begin
             m_phase = 2; m_cnt = 0; m_anim = 0; expl = 1'b1;
           end
         end
      default: if (tk) begin
           m_cnt++;
           m_anim = (m_anim + 1) % 4;
           if (m_cnt == 30) begin
             m_phase = 0; m_cnt = 0;
           end
         end
    endcase
    e.busy    = (m_phase != 0);
    e.explode = expl;
    q.push_back(e);
  endtask

  task automatic pick(output int px, output int py, output bit act);
    int r, ocx, ocy;
    r = $urandom_range(0, 9);
    if (r < 2) begin
      px = $urandom_range(0, 2047);
      py = $urandom_range(0, 2047);
    end else begin
      ocx = m_bx + $urandom_range(0, 6) - 3;
      ocy = m_by + $urandom_range(0, 6) - 3;
      if (r < 5) ocy = m_by;
      else if (r < 8) ocx = m_bx;
      px = 80 + ocx * 32 + $urandom_range(0, 31);
      py = 48 + ocy * 32 + $urandom_range(0, 31);
      if (px < 0) px = $urandom_range(0, 79);
      if (py < 0) py = $urandom_range(0, 47);
    end
    act = ($urandom_range(0, 7) != 0);
  endtask

  task automatic run_bomb(input int cx, input int cy, input int abort_blast);
    int px, py;
    bit act, pr;
    step(1'b1, cx, cy, 1'($urandom_range(0, 1)), 1'b1, 80 + cx * 32 + 5, 48 + cy * 32 + 5);
    for (int n = 0; n < 4000 && m_phase != 0; n++) begin
      if (abort_blast >= 0 && m_phase == 2 && m_cnt == abort_blast) return;
      pick(px, py, act);
      if ($urandom_range(0, 3) == 0) begin
        px = 80 + m_bx * 32 + 5;
        py = 48 + m_by * 32 + 5;
      end
      pr = ($urandom_range(0, 3) == 0);
      step(pr, 2, 2, 1'($urandom_range(0, 2) == 0), act, px, py);
    end
  endtask

  initial begin : stim
    int px, py;
    bit act;
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    active     = 1'b0;
    x          = '0;
    y          = '0;
    place_req  = 1'b0;
    place_cx   = '0;
    place_cy   = '0;
    #23;
    chk("reset_busy",    int'(busy),        0);
    chk("reset_explode", int'(explode),     0);
    chk("reset_bomb",    int'(bomb_color),  137);
    chk("reset_flame",   int'(flame_color), 137);
    @(negedge clk);
    reset_n = 1'b1;

    run_bomb(3, 4, -1);
    run_bomb(0, 0, -1);
    step(1'b0, 0, 0, 1'b0, 1'b1, 79, 60);

    // Out-of-range placements are dropped.
    step(1'b1, 15, 3, 1'b0, 1'b1, 100, 100);
    step(1'b1, 4, 13, 1'b1, 1'b1, 100, 100);
    step(1'b0, 0, 0, 1'b0, 1'b1, 100, 100);

    run_bomb(7, 6, 10);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_busy",  int'(busy),        0);
    chk("async_flame", int'(flame_color), 137);
    chk("async_bomb",  int'(bomb_color),  137);
    m_phase = 0;
    m_cnt   = 0;
    m_anim  = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 0, 0, 1'b1, 1'b1, 80 + 7 * 32 + 3, 48 + 6 * 32 + 3);
    step(1'b0, 0, 0, 1'b0, 1'b1, 80 + 7 * 32 + 3, 48 + 6 * 32 + 3);

    for (int i = 0; i < 4; i++) begin
      run_bomb($urandom_range(0, 15), $urandom_range(0, 13), -1);
      pick(px, py, act);
      step(1'b0, 0, 0, 1'b0, act, px, py);
    end
    run_bomb(14, 12, -1);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
